// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline slice: instruction width, the bubble
// instruction, and the fetch controller state encoding.
package mips_pkg;

    localparam int INSTR_W = 32;

    // ori $0,$0,0 -- must match the decode stage's instruction reset value
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h3400_0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        FAULT = 2'd3
    } fetch_state_e;

    // Address tagged onto a bubble so decode re-presents the same fetch address.
    function automatic logic [INSTR_W-1:0] bubble_pc(input logic [INSTR_W-1:0] pc);
        return pc - INSTR_W'(4);
    endfunction

endpackage

// File: rtl/register.sv
// Generic enabled register with asynchronous active-high reset to value D.
module register #(
    parameter int           W = 32,
    parameter logic [W-1:0] D = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= D;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: issues decode's next address over a req/gnt/rvalid
// handshake, injects NOP bubbles while memory is pending, flags sticky faults.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR,
    parameter int unsigned WAIT_W    = 8,
    parameter int unsigned MAX_WAIT  = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] next_pc_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    input  logic        imem_gnt_in,
    input  logic        imem_rvalid_in,
    input  logic [31:0] imem_rdata_in,
    output logic [31:0] instr_out,
    output logic [31:0] pc_seq_out,
    output logic        instr_valid_out,
    output logic        fault_out,
    output logic [31:0] fault_addr_out,
    output logic [31:0] fetch_count_out
);

    fetch_state_e      state, state_next;
    logic [WAIT_W-1:0] wait_cnt;
    logic [31:0]       pending_pc;
    logic [31:0]       fault_addr;
    logic [31:0]       fetch_count;
    logic [31:0]       fault_d;
    logic [31:0]       bubble_src;
    logic              pend_en;
    logic              fault_en;
    logic              accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wait_cnt <= '0;
        else if (pend_en)
            wait_cnt <= '0;
        else if (state == WAIT && !imem_rvalid_in)
            wait_cnt <= wait_cnt + WAIT_W'(1);
    end

    always_comb begin
        state_next   = state;
        imem_req_out = 1'b0;
        pend_en      = 1'b0;
        fault_en     = 1'b0;
        fault_d      = pending_pc;
        accept       = 1'b0;
        bubble_src   = next_pc_in;
        case (state)
            IDLE: state_next = REQ;
            REQ: begin
                if (next_pc_in[1:0] != 2'b00) begin
                    state_next = FAULT;
                    fault_en   = 1'b1;
                    fault_d    = next_pc_in;
                end else begin
                    imem_req_out = 1'b1;
                    if (imem_gnt_in) begin
                        pend_en    = 1'b1;
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                bubble_src = pending_pc;
                if (imem_rvalid_in) begin
                    accept     = 1'b1;
                    state_next = REQ;
                end else if (wait_cnt == WAIT_W'(MAX_WAIT - 1)) begin
                    // this cycle completes the MAX_WAIT-th WAIT cycle without data
                    state_next = FAULT;
                    fault_en   = 1'b1;
                end
            end
            FAULT: bubble_src = fault_addr;
            default: state_next = IDLE;
        endcase
    end

    register #(.W(32), .D(32'h0)) u_pending_pc (
        .clk   (clk),
        .reset (reset),
        .en    (pend_en),
        .d     (next_pc_in),
        .q     (pending_pc)
    );

    register #(.W(32), .D(32'h0)) u_fault_addr (
        .clk   (clk),
        .reset (reset),
        .en    (fault_en),
        .d     (fault_d),
        .q     (fault_addr)
    );

    register #(.W(32), .D(32'h0)) u_fetch_count (
        .clk   (clk),
        .reset (reset),
        .en    (accept),
        .d     (fetch_count + 32'd1),
        .q     (fetch_count)
    );

    assign imem_addr_out   = next_pc_in;
    assign instr_out       = accept ? imem_rdata_in : NOP_INSTR;
    assign pc_seq_out      = accept ? pending_pc : bubble_pc(bubble_src);
    assign instr_valid_out = accept;
    assign fault_out       = (state == FAULT);
    assign fault_addr_out  = fault_addr;
    assign fetch_count_out = fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Table-driven scoreboard bench for fetch_stage (instantiated with MAX_WAIT=4).
module tb_fetch_stage;
    import mips_pkg::*;

    localparam logic [31:0] N = 32'h3400_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] next_pc_in;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic        imem_gnt_in;
    logic        imem_rvalid_in;
    logic [31:0] imem_rdata_in;
    logic [31:0] instr_out;
    logic [31:0] pc_seq_out;
    logic        instr_valid_out;
    logic        fault_out;
    logic [31:0] fault_addr_out;
    logic [31:0] fetch_count_out;

    always #5 clk = ~clk;

    fetch_stage #(
        .NOP_INSTR (32'h3400_0000),
        .WAIT_W    (8),
        .MAX_WAIT  (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .next_pc_in      (next_pc_in),
        .imem_req_out    (imem_req_out),
        .imem_addr_out   (imem_addr_out),
        .imem_gnt_in     (imem_gnt_in),
        .imem_rvalid_in  (imem_rvalid_in),
        .imem_rdata_in   (imem_rdata_in),
        .instr_out       (instr_out),
        .pc_seq_out      (pc_seq_out),
        .instr_valid_out (instr_valid_out),
        .fault_out       (fault_out),
        .fault_addr_out  (fault_addr_out),
        .fetch_count_out (fetch_count_out)
    );

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pcs;
        logic        valid;
        logic        fault;
        logic [31:0] faddr;
        logic [31:0] cnt;
    } exp_t;

    typedef struct {
        logic        rst;
        logic [31:0] pc;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        exp_t        e;
    } vec_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic add(input logic rst, input logic [31:0] pc, input logic gnt, input logic rv,
                       input logic [31:0] rdata, input logic req, input logic [31:0] instr,
                       input logic [31:0] pcs, input logic valid, input logic fault,
                       input logic [31:0] faddr, input logic [31:0] cnt);
        vec_t v;
        v.rst     = rst;
        v.pc      = pc;
        v.gnt     = gnt;
        v.rv      = rv;
        v.rdata   = rdata;
        v.e.req   = req;
        v.e.addr  = pc;
        v.e.instr = instr;
        v.e.pcs   = pcs;
        v.e.valid = valid;
        v.e.fault = fault;
        v.e.faddr = faddr;
        v.e.cnt   = cnt;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s row %0d: got %h, expected %h", name, row, act, exp);
        end
    endtask

    initial begin
        exp_t e;

        // reset, IDLE, REQ without grant
        repeat (3) add(1, 32'h0040_0000, 0, 0, 0, 0, N, 32'h003f_fffc, 0, 0, 0, 0);
        add(0, 32'h0040_0000, 0, 0, 0, 0, N, 32'h003f_fffc, 0, 0, 0, 0);
        repeat (3) add(0, 32'h0040_0000, 0, 0, 0, 1, N, 32'h003f_fffc, 0, 0, 0, 0);
        // grant, then data in next cycle
        add(0, 32'h0040_0000, 1, 0, 0, 1, N, 32'h003f_fffc, 0, 0, 0, 0);
        add(0, 32'h0040_0000, 0, 1, 32'h2008_0005, 0, 32'h2008_0005, 32'h0040_0000, 1, 0, 0, 0);
        // second fetch with two wait cycles
        add(0, 32'h0040_0004, 1, 0, 0, 1, N, 32'h0040_0000, 0, 0, 0, 1);
        repeat (2) add(0, 32'h0040_0004, 0, 0, 0, 0, N, 32'h0040_0000, 0, 0, 0, 1);
        add(0, 32'h0040_0004, 0, 1, 32'h8c09_0000, 0, 32'h8c09_0000, 32'h0040_0004, 1, 0, 0, 1);
        // spurious rvalid in REQ, then grant and timeout after 4 WAIT cycles
        add(0, 32'h0040_0008, 0, 1, 32'hdead_beef, 1, N, 32'h0040_0004, 0, 0, 0, 2);
        add(0, 32'h0040_0008, 1, 0, 0, 1, N, 32'h0040_0004, 0, 0, 0, 2);
        repeat (4) add(0, 32'h0040_0008, 0, 0, 0, 0, N, 32'h0040_0004, 0, 0, 0, 2);
        add(0, 32'h0040_0008, 0, 1, 32'hcafe_f00d, 0, N, 32'h0040_0004, 0, 1, 32'h0040_0008, 2);
        add(0, 32'h0040_000c, 0, 0, 0, 0, N, 32'h0040_0004, 0, 1, 32'h0040_0008, 2);
        // reset clears fault; bubble pc wraps below zero
        add(1, 32'h0000_0000, 0, 0, 0, 0, N, 32'hffff_fffc, 0, 0, 0, 0);
        add(1, 32'h0040_0000, 0, 0, 0, 0, N, 32'h003f_fffc, 0, 0, 0, 0);
        // spurious rvalid in IDLE, then reset during WAIT
        add(0, 32'h0040_0000, 0, 1, 32'h1111_1111, 0, N, 32'h003f_fffc, 0, 0, 0, 0);
        add(0, 32'h0040_0000, 1, 0, 0, 1, N, 32'h003f_fffc, 0, 0, 0, 0);
        add(0, 32'h0040_0000, 0, 0, 0, 0, N, 32'h003f_fffc, 0, 0, 0, 0);
        add(1, 32'h0040_0000, 0, 0, 0, 0, N, 32'h003f_fffc, 0, 0, 0, 0);
        add(0, 32'h0040_0000, 0, 0, 0, 0, N, 32'h003f_fffc, 0, 0, 0, 0);
        // wait counter restarted: data on the 4th WAIT cycle is still accepted
        add(0, 32'h0040_0000, 1, 0, 0, 1, N, 32'h003f_fffc, 0, 0, 0, 0);
        repeat (3) add(0, 32'h0040_0000, 0, 0, 0, 0, N, 32'h003f_fffc, 0, 0, 0, 0);
        add(0, 32'h0040_0000, 0, 1, 32'h0123_4567, 0, 32'h0123_4567, 32'h0040_0000, 1, 0, 0, 0);
        // misaligned address: no request even with gnt high, then sticky fault
        add(0, 32'h0040_0002, 1, 0, 0, 0, N, 32'h003f_fffe, 0, 0, 0, 1);
        add(0, 32'h0040_0010, 0, 0, 0, 0, N, 32'h003f_fffe, 0, 1, 32'h0040_0002, 1);
        add(0, 32'h0040_0010, 0, 1, 32'h2222_2222, 0, N, 32'h003f_fffe, 0, 1, 32'h0040_0002, 1);
        add(1, 32'h0040_0000, 0, 0, 0, 0, N, 32'h003f_fffc, 0, 0, 0, 0);

        reset          = 1'b1;
        next_pc_in     = 32'h0040_0000;
        imem_gnt_in    = 1'b0;
        imem_rvalid_in = 1'b0;
        imem_rdata_in  = '0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            reset          = vecs[i].rst;
            next_pc_in     = vecs[i].pc;
            imem_gnt_in    = vecs[i].gnt;
            imem_rvalid_in = vecs[i].rv;
            imem_rdata_in  = vecs[i].rdata;
            sb.push_back(vecs[i].e);
            @(negedge clk);
            e = sb.pop_front();
            chk("req", i, {31'b0, imem_req_out}, {31'b0, e.req});
            if (e.req)
                chk("addr", i, imem_addr_out, e.addr);
            chk("instr", i, instr_out, e.instr);
            chk("pc_seq", i, pc_seq_out, e.pcs);
            chk("valid", i, {31'b0, instr_valid_out}, {31'b0, e.valid});
            chk("fault", i, {31'b0, fault_out}, {31'b0, e.fault});
            chk("fault_addr", i, fault_addr_out, e.faddr);
            chk("count", i, fetch_count_out, e.cnt);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
